// File: rtl/octree_anchor_updater.sv
// Octree anchor updater: responder side of the add/del anchor handshake.
// Walks the octree node SRAM with read-modify-write of per-node child masks.
// ADD sets the path bits root-downward; DEL clears the leaf bit and prunes
// upward while masks become empty.
// Optional build macro: OCTREE_UPD_WSKIP_EN (skip the write when the mask is
// unchanged; DEL then terminates without pruning).
//
// Request handshake: add_anchor/del_anchor are single-cycle pulses accepted
// only in IDLE; anything seen while busy is dropped. Exactly one add_done or
// del_done pulse answers each accepted request, with upd_err alongside it
// when the request was rejected (both ops at once, or a bad level).
module octree_anchor_updater #(
    parameter int MAX_LEVEL = 4,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             add_anchor,
    input  logic                             del_anchor,
    input  logic [3*MAX_LEVEL-1:0]           anchor_pos,
    input  logic [$clog2(MAX_LEVEL+1)-1:0]   anchor_level,
    output logic                             add_done,
    output logic                             del_done,
    output logic                             upd_err,
    output logic                             busy,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [7:0]                       mem_wdata,
    input  logic [7:0]                       mem_rdata
);

    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [3*MAX_LEVEL-1:0] pos_q;
    logic [LW-1:0]          tgt_q;
    logic [LW-1:0]          cur_q;
    logic                   op_add_q;
    logic                   op_del_q;
    logic                   err_q;
    logic [7:0]             data_q;
    logic [CW-1:0]          wcnt_q;
    logic [ADDR_W-1:0]      addr_hold;
    logic [7:0]             wdata_hold;

    logic [2:0]             oct_cur;
    logic [ADDR_W-1:0]      node_idx;
    logic [ADDR_W-1:0]      node_addr;
    logic [7:0]             new_mask;
    logic                   lvl_ok;
    logic                   wait_last;
    logic                   add_last;
    logic [ADDR_W-1:0]      base_tab [0:(1<<LW)-1];

    // Start address of level l: number of nodes above it, (8^l-1)/7.
    function automatic logic [ADDR_W-1:0] base_of(input int l);
        int s;
        s = 0;
        for (int k = 0; k < l; k++) s = s + (1 << (3 * k));
        return ADDR_W'(s);
    endfunction

    function automatic logic [7:0] modify(input logic [7:0] m, input logic [2:0] o,
                                          input logic add);
        return add ? (m | (8'b1 << o)) : (m & ~(8'b1 << o));
    endfunction

    genvar g;
    for (g = 0; g < (1 << LW); g++) begin : g_base
        assign base_tab[g] = base_of(g);
    end

    // Node address of the current level: base plus the octants above it.
    always_comb begin
        oct_cur  = 3'd0;
        node_idx = '0;
        for (int k = 0; k < MAX_LEVEL; k++) begin
            if (int'(cur_q) == k) oct_cur = pos_q[3*k +: 3];
            if (k < int'(cur_q)) node_idx = {node_idx[ADDR_W-4:0], pos_q[3*k +: 3]};
        end
        node_addr = base_tab[cur_q] + node_idx;
    end

    assign new_mask  = modify(data_q, oct_cur, op_add_q);
    assign lvl_ok    = (anchor_level != '0) && (anchor_level <= LW'(MAX_LEVEL));
    assign wait_last = (wcnt_q == CW'(RD_LAT - 1));
    assign add_last  = (cur_q == tgt_q - LW'(1));

`ifdef OCTREE_UPD_WSKIP_EN
    logic [7:0] rd_mask_mod;
    assign rd_mask_mod = modify(mem_rdata, oct_cur, op_add_q);
`endif

    // Next-state and strobe decode.
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        add_done = 1'b0;
        del_done = 1'b0;
        upd_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (add_anchor || del_anchor)
                    state_nx = ((add_anchor && del_anchor) || !lvl_ok) ? S_DONE : S_RD;
            end
            S_RD: begin
                mem_en   = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
`ifdef OCTREE_UPD_WSKIP_EN
                    if (rd_mask_mod == mem_rdata)
                        state_nx = (op_add_q && !add_last) ? S_RD : S_DONE;
                    else
                        state_nx = S_WR;
`else
                    state_nx = S_WR;
`endif
                end
            end
            S_WR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                if (op_add_q)
                    state_nx = add_last ? S_DONE : S_RD;
                else
                    state_nx = ((new_mask != 8'd0) || (cur_q == '0)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                add_done = op_add_q;
                del_done = op_del_q;
                upd_err  = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign mem_addr  = (state == S_RD || state == S_WR) ? node_addr : addr_hold;
    assign mem_wdata = (state == S_WR) ? new_mask : wdata_hold;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Request latch, level walk, read capture and held bus values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q      <= '0;
            tgt_q      <= '0;
            cur_q      <= '0;
            op_add_q   <= 1'b0;
            op_del_q   <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= 8'd0;
            wcnt_q     <= '0;
            addr_hold  <= '0;
            wdata_hold <= 8'd0;
        end else begin
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
            if (state == S_IDLE && (add_anchor || del_anchor)) begin
                pos_q    <= anchor_pos;
                tgt_q    <= anchor_level;
                op_add_q <= add_anchor;
                op_del_q <= del_anchor && !add_anchor;
                err_q    <= (add_anchor && del_anchor) || !lvl_ok;
                cur_q    <= add_anchor ? '0 : anchor_level - LW'(1);
            end
            if (state == S_RD) wcnt_q <= '0;
            if (state == S_WAIT) begin
                wcnt_q <= wcnt_q + CW'(1);
                if (wait_last) data_q <= mem_rdata;
            end
            // Moving to another node: ADD descends, DEL prunes upward.
            if (state != S_IDLE && state_nx == S_RD)
                cur_q <= op_add_q ? cur_q + LW'(1) : cur_q - LW'(1);
        end
    end

endmodule

// File: tb/tb_octree_anchor_updater.sv
// Directed bench for octree_anchor_updater with a 1-cycle-latency SRAM model.
module tb_octree_anchor_updater;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        add_anchor, del_anchor;
    logic [11:0] anchor_pos;
    logic [2:0]  anchor_level;
    logic        add_done, del_done, upd_err, busy;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  mem [0:1023];
    logic        mem_clr, bd_we;
    logic [9:0]  bd_addr;
    logic [7:0]  bd_data;

    int tests_run = 0;
    int tests_failed = 0;

    octree_anchor_updater dut (
        .clk(clk), .rst_n(rst_n),
        .add_anchor(add_anchor), .del_anchor(del_anchor),
        .anchor_pos(anchor_pos), .anchor_level(anchor_level),
        .add_done(add_done), .del_done(del_done), .upd_err(upd_err), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: registered read (RD_LAT=1), write on strobe, bench backdoor.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'd0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else begin
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
            if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ctl = {mem_en, mem_we, add_done, del_done, upd_err, busy}; addr/wdata < 0 skip.
    task automatic cyc(input string tag, input logic [5:0] ctl, input int addr, input int wdata);
        chk({tag, " ctl"}, {26'd0, mem_en, mem_we, add_done, del_done, upd_err, busy}, {26'd0, ctl});
        if (addr >= 0)  chk({tag, " addr"}, {22'd0, mem_addr}, addr);
        if (wdata >= 0) chk({tag, " wdata"}, {24'd0, mem_wdata}, wdata);
    endtask

    // Accept edge; returns positioned in the first cycle after accept.
    task automatic req(input logic a, input logic d, input logic [11:0] pos, input logic [2:0] lvl);
        add_anchor   = a;
        del_anchor   = d;
        anchor_pos   = pos;
        anchor_level = lvl;
        tick();
        add_anchor = 1'b0;
        del_anchor = 1'b0;
    endtask

    // One read-modify-write node visit: RD, WAIT, WR.
    task automatic node_rw(input string tag, input int addr, input int wdata);
        cyc({tag, " rd"}, 6'b100001, addr, -1);
        tick();
        cyc({tag, " wait"}, 6'b000001, -1, -1);
        tick();
        cyc({tag, " wr"}, 6'b110001, addr, wdata);
        tick();
    endtask

    task automatic backdoor(input logic [9:0] a, input logic [7:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        tick();
        bd_we = 1'b0;
    endtask

    int exp_a [4] = '{0, 3, 32, 261};
    int exp_w [4] = '{8'h0E, 8'h80, 8'h10, 8'h02};

    initial begin
        rst_n = 1'b0; mem_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        add_anchor = 1'b0; del_anchor = 1'b0; anchor_pos = '0; anchor_level = '0;
        tick(); tick(); tick();
        cyc("reset", 6'b000000, 0, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        tick();

        // ADD oct={3,5}, L=2; a stray del pulse while busy must be ignored.
        req(1'b1, 1'b0, 12'h02B, 3'd2);
        cyc("add35 n0 rd", 6'b100001, 0, -1);
        del_anchor = 1'b1;
        tick();
        del_anchor = 1'b0;
        cyc("add35 n0 wait", 6'b000001, -1, -1);
        tick();
        cyc("add35 n0 wr", 6'b110001, 0, 8'h08);
        tick();
        node_rw("add35 n1", 4, 8'h20);
        cyc("add35 done", 6'b001001, -1, -1);
        tick();
        cyc("add35 idle", 6'b000000, -1, -1);
        chk("add35 mem0", {24'd0, mem[0]}, 8'h08);
        chk("add35 mem4", {24'd0, mem[4]}, 8'h20);

        // DEL oct={3,5}, L=2: leaf empties, prune to root.
        req(1'b0, 1'b1, 12'h02B, 3'd2);
        node_rw("del35 n1", 4, 8'h00);
        node_rw("del35 n0", 0, 8'h00);
        cyc("del35 done", 6'b000101, -1, -1);
        tick();
        cyc("del35 idle", 6'b000000, -1, -1);
        chk("del35 mem0", {24'd0, mem[0]}, 8'h00);
        chk("del35 mem4", {24'd0, mem[4]}, 8'h00);

        // DEL with a sibling present: stops after the leaf.
        backdoor(10'd4, 8'h21);
        backdoor(10'd0, 8'h08);
        req(1'b0, 1'b1, 12'h02B, 3'd2);
        node_rw("delsib n1", 4, 8'h01);
        cyc("delsib done", 6'b000101, -1, -1);
        tick();
        cyc("delsib idle", 6'b000000, -1, -1);
        chk("delsib mem4", {24'd0, mem[4]}, 8'h01);
        chk("delsib mem0", {24'd0, mem[0]}, 8'h08);

        // Rejected requests.
        req(1'b1, 1'b1, 12'h02B, 3'd2);
        cyc("both err", 6'b001011, -1, -1);
        tick();
        cyc("both idle", 6'b000000, -1, -1);
        req(1'b1, 1'b0, 12'h000, 3'd0);
        cyc("l0 err", 6'b001011, -1, -1);
        tick();
        cyc("l0 idle", 6'b000000, -1, -1);
        req(1'b0, 1'b1, 12'h000, 3'd5);
        cyc("l5 err", 6'b000111, -1, -1);
        tick();
        cyc("l5 idle", 6'b000000, -1, -1);

        // Reset during WAIT abandons the op.
        req(1'b1, 1'b0, 12'h02B, 3'd2);
        cyc("rst rd", 6'b100001, 0, -1);
        tick();
        cyc("rst wait", 6'b000001, -1, -1);
        rst_n = 1'b0;
        tick();
        cyc("rst out", 6'b000000, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc("rst quiet", 6'b000000, -1, -1);
        end
        chk("rst mem0", {24'd0, mem[0]}, 8'h08);

        // New ADD oct={1}, L=1 after reset completes normally.
        req(1'b1, 1'b0, 12'h001, 3'd1);
        node_rw("add1", 0, 8'h0A);
        cyc("add1 done", 6'b001001, -1, -1);
        tick();
        cyc("add1 idle", 6'b000000, -1, -1);

        // ADD of an already-present anchor.
        req(1'b1, 1'b0, 12'h001, 3'd1);
`ifdef OCTREE_UPD_WSKIP_EN
        cyc("addex rd", 6'b100001, 0, -1);
        tick();
        cyc("addex wait", 6'b000001, -1, -1);
        tick();
`else
        node_rw("addex", 0, 8'h0A);
`endif
        cyc("addex done", 6'b001001, -1, -1);
        tick();
        cyc("addex idle", 6'b000000, -1, -1);

        // ADD at the deepest level: oct={2,7,4,1}, L=4.
        req(1'b1, 1'b0, 12'h33A, 3'd4);
        for (int n = 0; n < 4; n++) node_rw($sformatf("deep n%0d", n), exp_a[n], exp_w[n]);
        cyc("deep done", 6'b001001, -1, -1);
        tick();
        cyc("deep idle", 6'b000000, -1, -1);
        chk("deep mem261", {24'd0, mem[261]}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
